tetris_key_actions: RTL and testbench
=====================================

Name: tetris_key_actions

Overview:
- Consumes decoded keyboard events (scan code, make/break, event-valid pulse) from the PS/2 keyboard controller and converts them into one-cycle game action pulses for the Tetris game FSM.
- Runs in the game clock domain and synchronises the incoming event strobe.
- Tracks held keys and implements DAS/ARR auto-repeat for horizontal moves and a fixed repeat for soft drop.

Parameters:
- DAS_CYCLES, 4_250_000: delay from first horizontal pulse to first auto-repeat (170 ms at 25 MHz).
- ARR_CYCLES, 1_250_000: period between horizontal auto-repeat pulses (50 ms).
- SOFT_DROP_CYCLES, 1_250_000: period between soft-drop repeat pulses.
- CNT_W, 24: repeat counter width; must hold max(DAS_CYCLES, ARR_CYCLES, SOFT_DROP_CYCLES).

Ports:
- clk  in  1  game clock
- rst  in  1  synchronous, active-high reset
- scan_code  in  8  scan code from keyboard controller (other clock domain; stable while valid is high)
- make_break  in  1  1 = press, 0 = release; stable while valid is high
- key_event_valid  in  1  event strobe, ≥4 source cycles wide, asynchronous to clk
- clear_held  in  1  one-cycle flush of all held state and timers (game restart/over)
- act_left  out  1  move-left pulse
- act_right  out  1  move-right pulse
- act_down  out  1  soft-drop pulse
- act_rot_cw  out  1  rotate clockwise pulse
- act_rot_ccw  out  1  rotate counter-clockwise pulse
- act_drop  out  1  hard-drop pulse
- act_hold  out  1  hold-piece pulse
- act_pause  out  1  pause toggle pulse
- keys_held  out  8  held flags, index order {pause, hold, drop, ccw, cw, down, right, left}

Behaviour:
- Reset and clear: rst=1 clears all outputs, held flags, timers and synchroniser flops to 0. clear_held has the same effect except on the synchroniser flops. An event captured in the same cycle as clear_held is discarded.
- Synchronisation: key_event_valid passes through a 2-FF synchroniser plus a rising-edge detector. On the detected edge (cycle E), scan_code and make_break are registered.
- Decode happens at E+1. The immediate pulse is registered and asserted at E+2. Latency from the raw strobe rising edge is 4 clk cycles.
- Mapping (set-2 codes; the E0 prefix is already stripped by the controller):
  - 6B → left
  - 74 → right
  - 72 → down
  - 75 or 22 → rot_cw
  - 1A → rot_ccw
  - 29 → drop
  - 21 → hold
  - 76 or 4D → pause
  - Unmapped codes are ignored.
- Make of a key that is not held: set its held flag and emit one pulse.
- Make of an already-held key (typematic repeat): ignored. No pulse and no timer restart.
- Break: clear the held flag. Break of a key that is not held is ignored. Breaks never pulse.
- Rotations, drop, hold and pause are single-shot: they pulse only on make.
- Horizontal auto-repeat:
  - One active direction; the last-pressed direction wins.
  - On a new press of the active direction: immediate pulse, then load the counter with DAS_CYCLES and enter state DAS.
  - DAS expires (count reaches 0) → pulse, load ARR_CYCLES, enter state ARR. Each subsequent expiry pulses and reloads ARR_CYCLES.
  - Release of the active direction while the other is held: the other becomes active, with no immediate pulse and a fresh DAS_CYCLES load. If no direction remains held, go to IDLE.
  - Release of the inactive direction does not disturb the timer.
- Soft drop: immediate pulse on press, then one pulse every SOFT_DROP_CYCLES while held. Release → IDLE.
- Repeat FSM states: IDLE, DAS, ARR. The counter decrements once per cycle and expires on the cycle it holds 0. A reload value of N gives a pulse spacing of exactly N+1 cycles.
- Each act_* is high for exactly one cycle per pulse. At most one pulse per action per cycle; different actions may pulse in the same cycle.
- keys_held updates at E+2, together with the pulse.

Decomposition:
- Package tetris_input_pkg holds:
  - scan-code localparams (SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_DOWN=8'h72, SC_UP=8'h75, SC_X=8'h22, SC_Z=8'h1A, SC_SPACE=8'h29, SC_C=8'h21, SC_ESC=8'h76, SC_P=8'h4D)
  - an enum of action indices matching keys_held
  - a repeat-state enum {RPT_IDLE, RPT_DAS, RPT_ARR}
- Sub-module key_repeat_timer, instantiated twice (horizontal and down): inputs start and stop plus parameters FIRST_CYCLES and PERIOD_CYCLES; output is a one-cycle tick.

Test Plan:
- Make 6B with strobe 4 cycles wide → act_left single pulse 4 cycles after the strobe edge; keys_held[0]=1.
- Hold 6B for DAS+3×ARR with DAS=10, ARR=4 → left pulses at t0, t0+11, t0+16, t0+21, t0+26; break F0 6B → no further pulses and keys_held[0]=0.
- Hold left, then press right, then release right → right pulses immediately and later repeats; after right's break, left resumes with its first pulse 11 cycles later and no immediate pulse.
- Repeated make 75 three times without a break → exactly one act_rot_cw pulse. Break 22 (never held) → no effect.
- Make 72 with SOFT_DROP=5 → act_down pulses every 6 cycles. clear_held mid-hold → pulses stop and keys_held=0.
- Assert rst while left is in ARR, and send unmapped code 1C → all outputs 0, no pulses.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: scan codes, action indices and repeat-state encoding shared by
// the keyboard action front end.
`default_nettype none

package tetris_input_pkg;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;

  // Bit positions inside keys_held and the internal pulse vector.
  typedef enum logic [2:0] {
    ACT_LEFT  = 3'd0,
    ACT_RIGHT = 3'd1,
    ACT_DOWN  = 3'd2,
    ACT_CW    = 3'd3,
    ACT_CCW   = 3'd4,
    ACT_DROP  = 3'd5,
    ACT_HOLD  = 3'd6,
    ACT_PAUSE = 3'd7
  } act_idx_t;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_DAS  = 2'd1,
    RPT_ARR  = 2'd2
  } rpt_state_t;

  typedef struct packed {
    logic     hit;
    act_idx_t idx;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d.hit = 1'b1;
    d.idx = ACT_LEFT;
    case (code)
      SC_LEFT:        d.idx = ACT_LEFT;
      SC_RIGHT:       d.idx = ACT_RIGHT;
      SC_DOWN:        d.idx = ACT_DOWN;
      SC_UP, SC_X:    d.idx = ACT_CW;
      SC_Z:           d.idx = ACT_CCW;
      SC_SPACE:       d.idx = ACT_DROP;
      SC_C:           d.idx = ACT_HOLD;
      SC_ESC, SC_P:   d.idx = ACT_PAUSE;
      default:        d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: start loads FIRST_CYCLES, each expiry emits a one-cycle tick and
// reloads PERIOD_CYCLES; a reload of N spaces ticks N+1 cycles apart.
`default_nettype none

module key_repeat_timer
  import tetris_input_pkg::*;
#(
  parameter int FIRST_CYCLES  = 10,
  parameter int PERIOD_CYCLES = 4,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic tick
);

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick    <= tick_d;
    end
  end

  // A start or stop in the expiry cycle swallows that tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (stop) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = RPT_DAS;
      cnt_d   = CNT_W'(FIRST_CYCLES);
    end else if (state_q != RPT_IDLE) begin
      if (cnt_q == '0) begin
        tick_d  = 1'b1;
        state_d = RPT_ARR;
        cnt_d   = CNT_W'(PERIOD_CYCLES);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tetris_key_actions.sv
// tetris_key_actions: turns synchronised keyboard make/break events into one-cycle
// game action pulses with DAS/ARR horizontal repeat and soft-drop repeat.
`default_nettype none

module tetris_key_actions
  import tetris_input_pkg::*;
#(
  parameter int DAS_CYCLES       = 4_250_000,
  parameter int ARR_CYCLES       = 1_250_000,
  parameter int SOFT_DROP_CYCLES = 1_250_000,
  parameter int CNT_W            = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  input  logic       key_event_valid,
  input  logic       clear_held,
  output logic       act_left,
  output logic       act_right,
  output logic       act_down,
  output logic       act_rot_cw,
  output logic       act_rot_ccw,
  output logic       act_drop,
  output logic       act_hold,
  output logic       act_pause,
  output logic [7:0] keys_held
);

  logic       sync1, sync2, sync3;
  logic       rise;
  logic       cap_valid;
  logic [7:0] cap_code;
  logic       cap_make;
  key_dec_t   dec;
  logic [7:0] held_q, held_d;
  logic [7:0] pulse_q, pulse_d;
  logic       dir_q, dir_d;
  logic       other_held, releasing_active;
  logic       h_start, h_stop, d_start, d_stop;
  logic       h_tick, d_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= key_event_valid;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // Source-domain data is stable while the strobe is high, so capture on the edge.
  always_ff @(posedge clk) begin
    if (rst || clear_held) begin
      cap_valid <= 1'b0;
      cap_code  <= '0;
      cap_make  <= 1'b0;
    end else begin
      cap_valid <= rise;
      if (rise) begin
        cap_code <= scan_code;
        cap_make <= make_break;
      end
    end
  end

  assign dec              = decode_key(cap_code);
  assign other_held       = (dec.idx == ACT_LEFT) ? held_q[ACT_RIGHT] : held_q[ACT_LEFT];
  assign releasing_active = ((dec.idx == ACT_LEFT) && !dir_q) ||
                            ((dec.idx == ACT_RIGHT) && dir_q);

  always_comb begin
    held_d  = held_q;
    pulse_d = '0;
    dir_d   = dir_q;
    h_start = 1'b0;
    h_stop  = 1'b0;
    d_start = 1'b0;
    d_stop  = 1'b0;
    if (cap_valid && dec.hit) begin
      if (cap_make && !held_q[dec.idx]) begin
        held_d[dec.idx]  = 1'b1;
        pulse_d[dec.idx] = 1'b1;
        case (dec.idx)
          ACT_LEFT, ACT_RIGHT: begin
            dir_d   = (dec.idx == ACT_RIGHT);
            h_start = 1'b1;
          end
          ACT_DOWN: d_start = 1'b1;
          default:  ;
        endcase
      end else if (!cap_make && held_q[dec.idx]) begin
        held_d[dec.idx] = 1'b0;
        if (dec.idx == ACT_DOWN) begin
          d_stop = 1'b1;
        end else if (releasing_active) begin
          // Hand over to the other direction silently, restarting DAS.
          if (other_held) begin
            dir_d   = ~dir_q;
            h_start = 1'b1;
          end else begin
            h_stop = 1'b1;
          end
        end
      end
    end
    if (clear_held) begin
      held_d  = '0;
      pulse_d = '0;
      dir_d   = 1'b0;
      h_start = 1'b0;
      d_start = 1'b0;
      h_stop  = 1'b1;
      d_stop  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      pulse_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      held_q  <= held_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
    end
  end

  key_repeat_timer #(
    .FIRST_CYCLES (DAS_CYCLES),
    .PERIOD_CYCLES(ARR_CYCLES),
    .CNT_W        (CNT_W)
  ) u_horiz_timer (
    .clk  (clk),
    .rst  (rst),
    .start(h_start),
    .stop (h_stop),
    .tick (h_tick)
  );

  key_repeat_timer #(
    .FIRST_CYCLES (SOFT_DROP_CYCLES),
    .PERIOD_CYCLES(SOFT_DROP_CYCLES),
    .CNT_W        (CNT_W)
  ) u_down_timer (
    .clk  (clk),
    .rst  (rst),
    .start(d_start),
    .stop (d_stop),
    .tick (d_tick)
  );

  assign act_left    = pulse_q[ACT_LEFT]  | (h_tick & ~dir_q);
  assign act_right   = pulse_q[ACT_RIGHT] | (h_tick & dir_q);
  assign act_down    = pulse_q[ACT_DOWN]  | d_tick;
  assign act_rot_cw  = pulse_q[ACT_CW];
  assign act_rot_ccw = pulse_q[ACT_CCW];
  assign act_drop    = pulse_q[ACT_DROP];
  assign act_hold    = pulse_q[ACT_HOLD];
  assign act_pause   = pulse_q[ACT_PAUSE];
  assign keys_held   = held_q;

endmodule

`default_nettype wire

// File: tb/tb_tetris_key_actions.sv
// tb_tetris_key_actions: directed and random key events checked every cycle against
// an event-time reference model of held keys and repeat schedules.
`default_nettype none

module tb_tetris_key_actions;

  localparam int DAS  = 10;
  localparam int ARR  = 4;
  localparam int SOFT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scan_code;
  logic       make_break;
  logic       key_event_valid;
  logic       clear_held;
  logic       act_left, act_right, act_down, act_rot_cw, act_rot_ccw;
  logic       act_drop, act_hold, act_pause;
  logic [7:0] keys_held;

  tetris_key_actions #(
    .DAS_CYCLES      (DAS),
    .ARR_CYCLES      (ARR),
    .SOFT_DROP_CYCLES(SOFT),
    .CNT_W           (24)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .scan_code      (scan_code),
    .make_break     (make_break),
    .key_event_valid(key_event_valid),
    .clear_held     (clear_held),
    .act_left       (act_left),
    .act_right      (act_right),
    .act_down       (act_down),
    .act_rot_cw     (act_rot_cw),
    .act_rot_ccw    (act_rot_ccw),
    .act_drop       (act_drop),
    .act_hold       (act_hold),
    .act_pause      (act_pause),
    .keys_held      (keys_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%02h expected=%02h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: pending events by the cycle their effect becomes visible,
  // held keys, and absolute cycle numbers of the next repeat pulses.
  typedef struct {
    int         apply;
    logic [7:0] code;
    logic       make;
  } ev_t;

  ev_t        pend[$];
  int         clr_cycle = -1;
  logic [7:0] m_held;
  logic [7:0] exp_act;
  int         m_hdir;
  bit         m_hact;
  int         m_hnext;
  bit         m_dact;
  int         m_dnext;

  function automatic int key_index(input logic [7:0] code);
    case (code)
      8'h6B:        return 0;
      8'h74:        return 1;
      8'h72:        return 2;
      8'h75, 8'h22: return 3;
      8'h1A:        return 4;
      8'h29:        return 5;
      8'h21:        return 6;
      8'h76, 8'h4D: return 7;
      default:      return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_held = '0;
    m_hdir = 0;
    m_hact = 0;
    m_dact = 0;
  endtask

  task automatic model_apply(input logic [7:0] code, input logic mk);
    int k;
    k = key_index(code);
    if (k < 0) return;
    if (mk && !m_held[k]) begin
      m_held[k]  = 1'b1;
      exp_act[k] = 1'b1;
      if (k <= 1) begin
        m_hdir  = k;
        m_hact  = 1;
        m_hnext = cyc + DAS + 1;
      end else if (k == 2) begin
        m_dact  = 1;
        m_dnext = cyc + SOFT + 1;
      end
    end else if (!mk && m_held[k]) begin
      m_held[k] = 1'b0;
      if (k == 2) m_dact = 0;
      else if (k <= 1 && m_hact && m_hdir == k) begin
        if (m_held[1-k]) begin
          m_hdir  = 1 - k;
          m_hnext = cyc + DAS + 1;
        end else begin
          m_hact = 0;
        end
      end
    end
  endtask

  task automatic model_step();
    ev_t keep[$];
    exp_act = '0;
    if (rst) begin
      model_clear();
      pend.delete();
      return;
    end
    if (cyc == clr_cycle) model_clear();
    foreach (pend[i]) begin
      if (cyc == clr_cycle && pend[i].apply <= cyc + 1) continue;
      if (pend[i].apply == cyc) model_apply(pend[i].code, pend[i].make);
      else if (pend[i].apply > cyc) keep.push_back(pend[i]);
    end
    pend = keep;
    if (m_hact && cyc == m_hnext) begin
      exp_act[m_hdir] = 1'b1;
      m_hnext = cyc + ARR + 1;
    end
    if (m_dact && cyc == m_dnext) begin
      exp_act[2] = 1'b1;
      m_dnext = cyc + SOFT + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check("act", {act_pause, act_hold, act_drop, act_rot_ccw, act_rot_cw,
                    act_down, act_right, act_left}, exp_act);
      check("held", keys_held, m_held);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] code, input logic mk, input int gap);
    ev_t e;
    @(negedge clk);
    scan_code       = code;
    make_break      = mk;
    key_event_valid = 1'b1;
    e.apply = cyc + 4;
    e.code  = code;
    e.make  = mk;
    pend.push_back(e);
    repeat (4) @(negedge clk);
    key_event_valid = 1'b0;
    scan_code       = 8'($urandom);
    make_break      = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_held = 1'b1;
    clr_cycle  = cyc + 1;
    @(negedge clk);
    clear_held = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] codes [14] = '{8'h6B, 8'h6B, 8'h74, 8'h74, 8'h72, 8'h72, 8'h75,
                             8'h22, 8'h1A, 8'h29, 8'h21, 8'h76, 8'h4D, 8'h1C};

  initial begin
    rst             = 1'b1;
    scan_code       = '0;
    make_break      = 1'b0;
    key_event_valid = 1'b0;
    clear_held      = 1'b0;
    model_clear();
    idle(3);
    rst = 1'b0;
    idle(3);

    // Left press, DAS then ARR repeats, then release.
    send_key(8'h6B, 1'b1, 3);
    idle(28);
    send_key(8'h6B, 1'b0, 10);

    // Left held, right overrides, right released hands back to left.
    send_key(8'h6B, 1'b1, 12);
    send_key(8'h74, 1'b1, 20);
    send_key(8'h74, 1'b0, 20);
    send_key(8'h6B, 1'b0, 8);

    // Typematic repeats of rotate and a break of a key never held.
    send_key(8'h75, 1'b1, 3);
    send_key(8'h75, 1'b1, 3);
    send_key(8'h75, 1'b1, 3);
    send_key(8'h22, 1'b0, 3);
    send_key(8'h75, 1'b0, 6);

    // Soft drop repeat interrupted by clear.
    send_key(8'h72, 1'b1, 20);
    do_clear();
    idle(12);

    // Reset while left is repeating, then an unmapped code.
    send_key(8'h6B, 1'b1, 25);
    do_reset();
    send_key(8'h1C, 1'b1, 10);

    // Random key traffic with occasional clears and long holds.
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) do_clear();
      else send_key(codes[$urandom_range(0, 13)], 1'($urandom_range(0, 1)),
                    (r < 4) ? $urandom_range(15, 35) : $urandom_range(3, 10));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
